// File: rtl/openframe_gpio_cfg_seq.sv
// Purpose : shadow/live configuration store for openframe GPIO pads with a paced apply sequencer.
// Latency : a shadow write lands at the next edge; pad i goes live (i+1)*STEP_DIV cycles after apply is accepted.
// Backpr. : none; writes while busy or to a nonexistent pad are dropped and flagged on cfg_err.
//
// Ports
//   wb_clk_i, wb_rst_i      : clock, asynchronous active-high reset
//   cfg_we/cfg_addr/wdata   : shadow write port (one 12-bit word per pad)
//   apply_req               : starts copying shadow -> live, one pad every STEP_DIV clocks
//   busy, done, cfg_err     : apply in progress, apply-complete pulse, rejected-write pulse
//   gpio_*                  : per-pad bits of the live words, straight from flops
//   cfg_rdata               : {live, shadow} of cfg_addr, one cycle later (only with GPIO_CFG_READBACK_EN)
//
// Optional feature macro: GPIO_CFG_READBACK_EN
module openframe_gpio_cfg_seq #(
  parameter int NPADS    = 44,
  parameter int STEP_DIV = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cfg_we,
  input  logic [5:0]       cfg_addr,
  input  logic [11:0]      cfg_wdata,
  input  logic             apply_req,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [NPADS-1:0] gpio_dm2,
  output logic [NPADS-1:0] gpio_dm1,
  output logic [NPADS-1:0] gpio_dm0,
  output logic [NPADS-1:0] gpio_inp_dis,
  output logic [NPADS-1:0] gpio_ib_mode_sel,
  output logic [NPADS-1:0] gpio_vtrip_sel,
  output logic [NPADS-1:0] gpio_slow_sel,
  output logic [NPADS-1:0] gpio_holdover,
  output logic [NPADS-1:0] gpio_analog_en,
  output logic [NPADS-1:0] gpio_analog_sel,
  output logic [NPADS-1:0] gpio_analog_pol,
  output logic [NPADS-1:0] gpio_oeb
`ifdef GPIO_CFG_READBACK_EN
  ,
  output logic [23:0]      cfg_rdata
`endif
);

  // dm=001 (input), oeb=1 (output driver off), everything else cleared
  localparam logic [11:0] RESET_WORD = 12'h801;
  localparam logic [5:0]  LAST_PAD   = 6'(NPADS - 1);
  localparam logic [7:0]  STEP_LAST  = 8'(STEP_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  pad_idx_q, pad_idx_d;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic        done_q, done_d;
  logic        cfg_err_q, cfg_err_d;
  logic [11:0] shadow_q [NPADS];
  logic [11:0] shadow_d [NPADS];
  logic [11:0] live_q   [NPADS];
  logic [11:0] live_d   [NPADS];
  logic        addr_ok;
  logic        wr_ok;

  assign addr_ok = ({26'd0, cfg_addr} < NPADS);
  // Shadow only accepts writes while idle, so an in-flight apply sees a stable image.
  assign wr_ok   = cfg_we && (state_q == IDLE) && addr_ok;

  always_comb begin
    state_d    = state_q;
    pad_idx_d  = pad_idx_q;
    step_cnt_d = step_cnt_q;
    done_d     = 1'b0;
    cfg_err_d  = cfg_we && !wr_ok;
    shadow_d   = shadow_q;
    live_d     = live_q;

    // A write in the same idle cycle as apply_req lands at this edge, well
    // before the first pad copy, so the apply naturally includes it.
    if (wr_ok) begin
      shadow_d[cfg_addr] = cfg_wdata;
    end

    if (state_q == IDLE) begin
      if (apply_req) begin
        state_d    = STEP;
        pad_idx_d  = 6'd0;
        step_cnt_d = 8'd0;
      end
    end else begin
      if (step_cnt_q == STEP_LAST) begin
        step_cnt_d       = 8'd0;
        live_d[pad_idx_q] = shadow_q[pad_idx_q];
        if (pad_idx_q == LAST_PAD) begin
          state_d   = IDLE;
          pad_idx_d = 6'd0;
          done_d    = 1'b1;
        end else begin
          pad_idx_d = pad_idx_q + 6'd1;
        end
      end else begin
        step_cnt_d = step_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      pad_idx_q  <= 6'd0;
      step_cnt_q <= 8'd0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int p = 0; p < NPADS; p++) begin
        shadow_q[p] <= RESET_WORD;
        live_q[p]   <= RESET_WORD;
      end
    end else begin
      state_q    <= state_d;
      pad_idx_q  <= pad_idx_d;
      step_cnt_q <= step_cnt_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      shadow_q   <= shadow_d;
      live_q     <= live_d;
    end
  end

  assign busy    = (state_q == STEP);
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

  for (genvar p = 0; p < NPADS; p++) begin : g_pad
    assign gpio_dm0[p]         = live_q[p][0];
    assign gpio_dm1[p]         = live_q[p][1];
    assign gpio_dm2[p]         = live_q[p][2];
    assign gpio_inp_dis[p]     = live_q[p][3];
    assign gpio_ib_mode_sel[p] = live_q[p][4];
    assign gpio_vtrip_sel[p]   = live_q[p][5];
    assign gpio_slow_sel[p]    = live_q[p][6];
    assign gpio_holdover[p]    = live_q[p][7];
    assign gpio_analog_en[p]   = live_q[p][8];
    assign gpio_analog_sel[p]  = live_q[p][9];
    assign gpio_analog_pol[p]  = live_q[p][10];
    assign gpio_oeb[p]         = live_q[p][11];
  end

`ifdef GPIO_CFG_READBACK_EN
  logic [23:0] cfg_rdata_q, cfg_rdata_d;

  always_comb begin
    cfg_rdata_d = 24'd0;
    if (addr_ok) begin
      cfg_rdata_d = {live_q[cfg_addr], shadow_q[cfg_addr]};
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cfg_rdata_q <= 24'd0;
    end else begin
      cfg_rdata_q <= cfg_rdata_d;
    end
  end

  assign cfg_rdata = cfg_rdata_q;
`endif

endmodule

// File: doc/openframe_gpio_cfg_seq.md
OPENFRAME_GPIO_CFG_SEQ -- requirements
Module: openframe_gpio_cfg_seq

Interface
REQ-001 SHALL have parameter NPADS, default 44; the number of openframe GPIO pads controlled.
REQ-002 SHALL have parameter STEP_DIV, default 4, legal range 1..255; the number of clocks between successive pad updates.
REQ-003 SHALL have port wb_clk_i, input, 1 bit; the single clock.
REQ-004 SHALL have port wb_rst_i, input, 1 bit; reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_we, input, 1 bit; shadow write strobe.
REQ-006 SHALL have port cfg_addr, input, 6 bits; pad index.
REQ-007 SHALL have port cfg_wdata, input, 12 bits; pad config word: [2:0] dm, [3] inp_dis, [4] ib_mode_sel, [5] vtrip_sel, [6] slow_sel, [7] holdover, [8] analog_en, [9] analog_sel, [10] analog_pol, [11] oeb.
REQ-008 SHALL have port apply_req, input, 1 bit; start of sequenced apply.
REQ-009 SHALL have port busy, output, 1 bit; high while an apply is in progress.
REQ-010 SHALL have port done, output, 1 bit; one-cycle pulse when an apply completes.
REQ-011 SHALL have port cfg_err, output, 1 bit; one-cycle pulse when a write is rejected.
REQ-012 SHALL have ports gpio_dm2/dm1/dm0, gpio_inp_dis, gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel, gpio_holdover, gpio_analog_en, gpio_analog_sel, gpio_analog_pol and gpio_oeb, each an output of NPADS bits, one bit per pad; all are registered.

Function
REQ-013 SHALL hold one 12-bit shadow word per pad and one 12-bit live word per pad; the live words drive the gpio_* outputs.
REQ-014 SHALL write cfg_wdata into shadow[cfg_addr] when cfg_we=1, busy=0 and cfg_addr<NPADS; the write takes effect at the next edge.
REQ-015 SHALL discard a write with cfg_we=1 and either busy=1 or cfg_addr>=NPADS, and SHALL pulse cfg_err on the following cycle.
REQ-016 SHALL implement FSM states IDLE and STEP.
  - IDLE -> STEP when apply_req=1.
  - STEP -> IDLE after the pad NPADS-1 update.
REQ-017 SHALL raise busy on the cycle after apply_req is accepted; apply_req while busy=1 SHALL be ignored.
REQ-018 SHALL, in STEP, copy shadow[i] to live[i] at the edge that ends the (i+1)*STEP_DIV-th cycle after acceptance, for i = 0..NPADS-1 in ascending order, one pad per update.
REQ-019 SHALL use the shadow contents as of the update edge for each pad; shadow is frozen while busy=1 by REQ-015.
REQ-020 SHALL pulse done on the cycle after the last pad update, with busy low in that same cycle.
REQ-021 SHALL, if apply_req and cfg_we are asserted in the same IDLE cycle, perform the write first, so the apply includes it.
REQ-022 SHALL use a pad-index counter of 6 bits and a step counter of 8 bits; neither counter shall wrap beyond its terminal value.

Reset
REQ-023 SHALL, on wb_rst_i=1, asynchronously force:
  - FSM to IDLE; busy=0, done=0, cfg_err=0; counters to 0.
  - every shadow and live word to 12'h801 (dm=3'b001, oeb=1, all other fields 0).
REQ-024 SHALL, if reset is asserted mid-apply, abandon the apply; partially updated pads return to the reset word.

Configuration
REQ-025 SHALL support macro GPIO_CFG_READBACK_EN.
  - Defined: adds output cfg_rdata[23:0], registered 1 cycle, = {live[cfg_addr], shadow[cfg_addr]}; reads 0 when cfg_addr>=NPADS; resets to 0.
  - Undefined: port and logic absent; all other behaviour is identical.

Verification
REQ-026 Reset: with wb_rst_i=1 -> gpio_dm0 all 1s; gpio_dm2, gpio_dm1, gpio_inp_dis all 0; gpio_oeb all 1s; busy=0.
REQ-027 Apply: write pad 5 = 12'h006, pulse apply_req at cycle 0 with STEP_DIV=4.
  - Cycle 1: busy=1.
  - Pad 5 dm=3'b110 and oeb=0 only after edge 24.
  - done at cycle 177, busy=0.
REQ-028 Rejected writes: write with cfg_addr=44 -> cfg_err pulse; no shadow change. Write during busy -> cfg_err pulse; value not applied.
REQ-029 Reset mid-apply: assert wb_rst_i at pad 20 -> all outputs return to the 12'h801 fields; busy=0; a new apply runs to completion.
REQ-030 Simultaneous events: apply_req together with write of pad 0 = 12'h106 -> pad 0 analog_en=1 after the first update. Second apply_req while busy -> ignored; exactly one done pulse.
REQ-031 Readback (GPIO_CFG_READBACK_EN defined): write pad 3 = 12'h0AA, no apply -> cfg_rdata = {12'h801, 12'h0AA}. After apply -> {12'h0AA, 12'h0AA}.
